fp_mul_scheduler: RTL and testbench

//  Shares one combinational IEEE-754 single-precision Multiplication datapath between NUM_REQ requesters.

---
 rtl/fp_mul_scheduler.sv | 156 +++++++++++++++
 tb/tb_fp_mul_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_scheduler.sv
// fp_mul_scheduler
// Shares one combinational single-precision multiplier between NUM_REQ
// requesters. A round-robin arbiter picks one request and registers its
// operands towards the multiplier. One cycle later the multiplier result and
// flags are captured into a tagged response. The response then waits on a
// valid/ready handshake before the next request can be granted.
//
// Ports
//   clk, reset             clock and synchronous active-high reset
//   req_valid/req_ready    per-requester handshake; req_ready is a one-hot grant
//   req_a, req_b           packed operands, requester i at [32*i+31:32*i]
//   mul_a/b_operand        registered operands driven to the multiplier
//   mul_result, mul_*flag  multiplier outputs, captured unmodified
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 index of the requester that owns the response
//   rsp_result, rsp_*flag  captured multiplier result and flags
//   busy                   high whenever a transaction is in flight
module fp_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            mul_a_operand,
  output logic [31:0]            mul_b_operand,
  input  logic [31:0]            mul_result,
  input  logic                   mul_exception,
  input  logic                   mul_overflow,
  input  logic                   mul_underflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_exception,
  output logic                   rsp_overflow,
  output logic                   rsp_underflow,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] gnt_sel;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] rr_next;
  logic            gnt_found;
  logic            rsp_fire;

  assign rsp_fire = rsp_valid & rsp_ready;

  // The pointer moves to the requester just after the one most recently
  // served. The explicit wrap keeps this correct when NUM_REQ is not a
  // power of two.
  assign rr_next = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  // Round-robin search. Candidates are visited starting at rr_ptr and
  // wrapping modulo NUM_REQ. The first candidate that is valid wins, so the
  // requester served most recently is the last one to be considered.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_sel   = cand;
      end
    end
  end

  // Next-state logic and combinational outputs.
  // The grant is only visible in IDLE. It is also forced low while reset is
  // asserted, so nobody sees a transfer that the reset is about to discard.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d = EXEC;
          if (!reset) begin
            req_ready[gnt_sel] = 1'b1;
          end
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and datapath registers.
  // Operands are latched at the grant and then held until the next grant.
  // The multiplier result is captured after one settle cycle. The response
  // stays frozen until the consumer accepts it. A reset clears everything,
  // so an in-flight operation is dropped without producing a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr        <= '0;
      gnt_id        <= '0;
      mul_a_operand <= '0;
      mul_b_operand <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_exception <= 1'b0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            mul_a_operand <= req_a[int'(gnt_sel) * 32 +: 32];
            mul_b_operand <= req_b[int'(gnt_sel) * 32 +: 32];
            gnt_id        <= gnt_sel;
          end
        end
        EXEC: begin
          rsp_result    <= mul_result;
          rsp_exception <= mul_exception;
          rsp_overflow  <= mul_overflow;
          rsp_underflow <= mul_underflow;
          rsp_id        <= gnt_id;
          rsp_valid     <= 1'b1;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= rr_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// tb_fp_mul_scheduler
// Scoreboard bench for fp_mul_scheduler.
//
// The multiplier is replaced by a stub. For the vectors that matter it
// returns known IEEE products, and for everything else it returns a
// scrambled value with varying flags. This lets the bench see that the
// correct operands were routed through and that the result and flags
// pass back unmodified.
//
// A reference model predicts each round-robin grant from the request
// pattern and pushes the expected response into a queue. A separate
// monitor pops the queue and compares it against every response the DUT
// presents.
module tb_fp_mul_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           mul_a_operand;
  logic [31:0]           mul_b_operand;
  logic [31:0]           mul_result;
  logic                  mul_exception;
  logic                  mul_overflow;
  logic                  mul_underflow;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_exception;
  logic                  rsp_overflow;
  logic                  rsp_underflow;
  logic                  busy;

  typedef struct {
    int          id;
    logic [31:0] result;
    logic [2:0]  flags;
    int          grantCycle;
  } exp_t;

  exp_t expQ[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cycle      = 0;
  int   grantCount = 0;
  bit   modelIdle  = 1'b1;
  int   rrModel    = 0;
  int   curGnt     = 0;
  bit   inResp     = 1'b0;

  fp_mul_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .mul_a_operand(mul_a_operand),
    .mul_b_operand(mul_b_operand),
    .mul_result(mul_result),
    .mul_exception(mul_exception),
    .mul_overflow(mul_overflow),
    .mul_underflow(mul_underflow),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .rsp_exception(rsp_exception),
    .rsp_overflow(rsp_overflow),
    .rsp_underflow(rsp_underflow),
    .busy(busy)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Cycle counter used to measure grant-to-response latency.
  always @(posedge clk) cycle <= cycle + 1;

  // Multiplier stand-in. The return value is packed as
  // {exception, overflow, underflow, result}.
  function automatic logic [34:0] mulStub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4234851F && b == 32'h427C851F) return {3'b000, 32'h453210E9};
    if (a == 32'h45800000 && b == 32'h45800000) return {3'b000, 32'h4B800000};
    if (a == 32'h7F800000 && b == 32'h7F800000) return {3'b110, 32'h00000000};
    return {a[2:0] ^ b[5:3], (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]}};
  endfunction

  assign {mul_exception, mul_overflow, mul_underflow, mul_result} = mulStub(mul_a_operand, mul_b_operand);

  // Shared comparison routine. Every check in the bench is counted here,
  // and every mismatch is reported on a single FAIL line.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Drives the request and response-ready inputs just after a rising edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [32*NUM_REQ-1:0] a,
                               input logic [32*NUM_REQ-1:0] b, input logic rdy);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
  endtask

  // Reference model, sampled on the falling edge.
  // While the model is idle, the next grant is the first valid requester
  // found by scanning from rrModel and wrapping around. When the grant is
  // made, the expected response is queued. The model then stays busy until
  // it observes the response handshake. After that the pointer moves to
  // the requester following the one just served.
  always @(negedge clk) begin
    int   g;
    int   idx;
    logic [34:0] m;
    exp_t e;
    if (reset) begin
      checkOutput("req_ready_in_reset", 64'(req_ready), 64'(0));
      expQ.delete();
      modelIdle = 1'b1;
      rrModel   = 0;
    end else begin
      checkOutput("busy", 64'(busy), 64'(!modelIdle));
      if (modelIdle) begin
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (rrModel + k) % NUM_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        checkOutput("req_ready_grant", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
        if (g >= 0) begin
          m            = mulStub(req_a[32*g +: 32], req_b[32*g +: 32]);
          e.id         = g;
          e.result     = m[31:0];
          e.flags      = m[34:32];
          e.grantCycle = cycle;
          expQ.push_back(e);
          curGnt    = g;
          modelIdle = 1'b0;
          grantCount++;
        end
      end else begin
        checkOutput("req_ready_busy", 64'(req_ready), 64'(0));
        if (rsp_valid && rsp_ready) begin
          modelIdle = 1'b1;
          rrModel   = (curGnt + 1) % NUM_REQ;
        end
      end
    end
  end

  // Response monitor. Every cycle a response is visible, it is compared
  // against the head of the expected queue, which also proves the response
  // is held stable under backpressure. The first cycle of each response
  // also checks that it arrived exactly two edges after the grant.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      inResp = 1'b0;
    end else if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("rsp_unexpected_valid", 64'(rsp_valid), 64'(0));
      end else begin
        e = expQ[0];
        if (!inResp) begin
          checkOutput("rsp_latency", 64'(cycle - e.grantCycle), 64'(2));
          inResp = 1'b1;
        end
        checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
        checkOutput("rsp_result", 64'(rsp_result), 64'(e.result));
        checkOutput("rsp_flags", 64'({rsp_exception, rsp_overflow, rsp_underflow}), 64'(e.flags));
        if (rsp_ready) begin
          void'(expQ.pop_front());
          inResp = 1'b0;
        end
      end
    end
  end

  // Waits until the model has seen n more grants, up to a cycle budget.
  task automatic waitGrants(input int n, input int budget);
    int target;
    target = grantCount + n;
    for (int i = 0; i < budget && grantCount < target; i++) begin
      @(posedge clk);
      #1;
    end
    if (grantCount < target) checkOutput("wait_grant_timeout", 64'(grantCount), 64'(target));
  endtask

  // Waits until every outstanding response has been delivered.
  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && !(modelIdle && expQ.size() == 0); i++) begin
      @(posedge clk);
      #1;
    end
    if (!(modelIdle && expQ.size() == 0)) checkOutput("drain_timeout", 64'(expQ.size()), 64'(0));
  endtask

  // Presents the same operands on every lane, so that whichever requester
  // in the mask is granted carries the intended values.
  task automatic issueOne(input logic [NUM_REQ-1:0] mask, input logic [31:0] a, input logic [31:0] b,
                          input logic rdy);
    applyStimulus(mask, {NUM_REQ{a}}, {NUM_REQ{b}}, rdy);
    waitGrants(1, 20);
    req_valid = '0;
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [32*NUM_REQ-1:0] aVec;
    logic [32*NUM_REQ-1:0] bVec;

    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mul_a", 64'(mul_a_operand), 64'(0));
    checkOutput("reset_mul_b", 64'(mul_b_operand), 64'(0));
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("reset_rsp_result", 64'(rsp_result), 64'(0));
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'(0));
    checkOutput("reset_rsp_flags", 64'({rsp_exception, rsp_overflow, rsp_underflow}), 64'(0));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] single request on requester 0");
    issueOne(4'b0001, 32'h4234851F, 32'h427C851F, 1'b1);
    waitDone(20);

    $display("[TB] all requesters, 4096*4096");
    resetPulse();
    applyStimulus(4'b1111, {NUM_REQ{32'h45800000}}, {NUM_REQ{32'h45800000}}, 1'b1);
    waitGrants(4, 40);
    req_valid = '0;
    waitDone(20);

    $display("[TB] response backpressure");
    issueOne(4'b0100, 32'h3FC00000, 32'h40200000, 1'b0);
    req_valid = 4'b1111;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    applyStimulus('0, req_a, req_b, 1'b1);
    waitDone(20);

    $display("[TB] alternating requesters 1 and 3");
    resetPulse();
    applyStimulus(4'b1010, {NUM_REQ{32'h12345678}}, {NUM_REQ{32'h9ABCDEF0}}, 1'b1);
    waitGrants(4, 40);
    req_valid = '0;
    waitDone(20);

    $display("[TB] infinity times infinity");
    issueOne(4'b0100, 32'h7F800000, 32'h7F800000, 1'b1);
    waitDone(20);

    $display("[TB] reset during execution");
    issueOne(4'b0001, 32'h11111111, 32'h22222222, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("abort_mul_a", 64'(mul_a_operand), 64'(0));
    checkOutput("abort_mul_b", 64'(mul_b_operand), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("abort_no_response", 64'(rsp_valid), 64'(0));
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        aVec[32*i +: 32] = $urandom;
        bVec[32*i +: 32] = $urandom;
        if ($urandom_range(7) == 0) begin
          aVec[32*i +: 32] = 32'h45800000;
          bVec[32*i +: 32] = 32'h45800000;
        end
      end
      applyStimulus(NUM_REQ'($urandom), aVec, bVec, ($urandom_range(3) != 0));
    end
    @(posedge clk);
    #1;
    applyStimulus('0, req_a, req_b, 1'b1);
    waitDone(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: a hard stop in case the run stalls somewhere.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
